// File: rtl/pc_sequencer_if.sv
// Fetch-side bus of the PC sequencer: shared-adder operands and sum, the fetch
// valid/ready handshake and the execute redirect request.
//   master : sequencer side (drives adder operands, PC, valid, wrong-path, misaligned)
//   slave  : environment side (adder, fetch unit, execute)
interface pc_sequencer_if #(
   parameter int unsigned DATA_WIDTH = 64
);
   logic [DATA_WIDTH-1:0] o_add_a;
   logic [DATA_WIDTH-1:0] o_add_b;
   logic [DATA_WIDTH-1:0] i_add_result;
   logic [DATA_WIDTH-1:0] o_pc;
   logic                  o_pc_valid;
   logic                  i_fetch_ready;
   logic                  o_wrong_path;
   logic                  i_redir_req;
   logic [DATA_WIDTH-1:0] i_redir_base;
   logic [DATA_WIDTH-1:0] i_redir_offset;
   logic                  i_redir_jalr;
   logic                  o_misaligned;

   modport master (
      output o_add_a, o_add_b, o_pc, o_pc_valid, o_wrong_path, o_misaligned,
      input  i_add_result, i_fetch_ready, i_redir_req, i_redir_base, i_redir_offset,
             i_redir_jalr
   );

   modport slave (
      input  o_add_a, o_add_b, o_pc, o_pc_valid, o_wrong_path, o_misaligned,
      output i_add_result, i_fetch_ready, i_redir_req, i_redir_base, i_redir_offset,
             i_redir_jalr
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer. Owns the PC, shares one external adder between the
// sequential increment and control-flow redirects, and offers each PC to fetch
// over a valid/ready handshake. A redirect arriving while a transfer is stalled
// is parked in a pending register and the stalled transfer is flagged wrong-path.
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - synchronous active-high reset
//   bus    - pc_sequencer_if.master (adder operands/sum, fetch handshake, redirect)
module pc_sequencer #(
   parameter int unsigned          DATA_WIDTH   = 64,
   parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
   parameter int unsigned          INSTR_BYTES  = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   pc_sequencer_if.master       bus
);

   localparam logic [DATA_WIDTH-1:0] IncrVal   = DATA_WIDTH'(INSTR_BYTES);
   localparam logic [DATA_WIDTH-1:0] AlignMask = DATA_WIDTH'(INSTR_BYTES - 1);

   typedef enum logic [1:0] {StBoot, StRun, StPend} state_e;

   state_e                state_q;
   logic [DATA_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] pend_q;
   logic                  pc_valid_q;
   logic                  wrong_path_q;
   logic                  misaligned_q;

   logic                  fire;
   logic [DATA_WIDTH-1:0] target;
   logic                  target_bad;

   assign fire = pc_valid_q & bus.i_fetch_ready;

   // Redirect always owns the adder in its cycle, even when it will be dropped.
   always_comb begin
      bus.o_add_a = pc_q;
      bus.o_add_b = IncrVal;
      if (bus.i_redir_req) begin
         bus.o_add_a = bus.i_redir_base;
         bus.o_add_b = bus.i_redir_offset;
      end
   end

   always_comb begin
      target = bus.i_add_result;
      if (bus.i_redir_jalr) begin
         target[0] = 1'b0;
      end
      target_bad = |(target & AlignMask);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= StBoot;
         pc_q         <= RESET_VECTOR;
         pend_q       <= '0;
         pc_valid_q   <= 1'b0;
         wrong_path_q <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         misaligned_q <= 1'b0;
         unique case (state_q)
            StBoot: begin
               // Redirects during boot are ignored.
               state_q    <= StRun;
               pc_q       <= RESET_VECTOR;
               pc_valid_q <= 1'b1;
            end
            StRun: begin
               if (bus.i_redir_req) begin
                  if (target_bad) begin
                     // Dropped redirect: the adder was not free for the increment,
                     // so the PC holds even if this transfer fired.
                     misaligned_q <= 1'b1;
                  end else if (fire) begin
                     pc_q <= target;
                  end else begin
                     // PC must stay stable under a stalled handshake.
                     pend_q       <= target;
                     state_q      <= StPend;
                     wrong_path_q <= 1'b1;
                  end
               end else if (fire) begin
                  pc_q <= bus.i_add_result;
               end
            end
            StPend: begin
               if (bus.i_redir_req) begin
                  if (target_bad) begin
                     misaligned_q <= 1'b1;
                  end else if (fire) begin
                     pc_q         <= target;
                     state_q      <= StRun;
                     wrong_path_q <= 1'b0;
                  end else begin
                     pend_q <= target; // newest redirect wins
                  end
               end else if (fire) begin
                  pc_q         <= pend_q;
                  state_q      <= StRun;
                  wrong_path_q <= 1'b0;
               end
            end
            default: begin
               state_q <= StBoot;
            end
         endcase
      end
   end

   assign bus.o_pc         = pc_q;
   assign bus.o_pc_valid   = pc_valid_q;
   assign bus.o_wrong_path = wrong_path_q;
   assign bus.o_misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a table of per-cycle inputs and expected
// outputs, followed by a hand-written reset-during-pending sequence.
module tb_pc_sequencer;
   localparam int unsigned DW = 64;

   typedef struct {
      logic          redir;
      logic [DW-1:0] base;
      logic [DW-1:0] off;
      logic          jalr;
      logic          ready;
      logic [DW-1:0] exp_pc;
      logic          exp_valid;
      logic          exp_wp;
      logic          exp_mis;
      logic [DW-1:0] exp_a;
      logic [DW-1:0] exp_b;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   vec_t vq[$];

   pc_sequencer_if #(.DATA_WIDTH(DW)) bus ();

   // External shared adder.
   assign bus.i_add_result = bus.o_add_a + bus.o_add_b;

   pc_sequencer #(
      .DATA_WIDTH  (DW),
      .RESET_VECTOR(64'h0),
      .INSTR_BYTES (4)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic r, logic [DW-1:0] b, logic [DW-1:0] o, logic j,
                               logic rdy, logic [DW-1:0] pc, logic v, logic wp, logic mis,
                               logic [DW-1:0] a, logic [DW-1:0] bb);
      vec_t t;
      t.redir = r;   t.base = b;       t.off = o;       t.jalr = j;   t.ready = rdy;
      t.exp_pc = pc; t.exp_valid = v;  t.exp_wp = wp;   t.exp_mis = mis;
      t.exp_a = a;   t.exp_b = bb;
      return t;
   endfunction

   task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(logic r, logic [DW-1:0] b, logic [DW-1:0] o, logic j, logic rdy);
      bus.i_redir_req    = r;
      bus.i_redir_base   = b;
      bus.i_redir_offset = o;
      bus.i_redir_jalr   = j;
      bus.i_fetch_ready  = rdy;
   endtask

   task automatic chk_regs(string tag, logic [DW-1:0] pc, logic v, logic wp, logic mis);
      chk({tag, " pc"}, bus.o_pc, pc);
      chk({tag, " valid"}, DW'(bus.o_pc_valid), DW'(v));
      chk({tag, " wrong_path"}, DW'(bus.o_wrong_path), DW'(wp));
      chk({tag, " misaligned"}, DW'(bus.o_misaligned), DW'(mis));
   endtask

   localparam logic [DW-1:0] M8  = 64'hFFFF_FFFF_FFFF_FFF8;
   localparam logic [DW-1:0] TOP = 64'hFFFF_FFFF_FFFF_FFF0;
   localparam logic [DW-1:0] TFC = 64'hFFFF_FFFF_FFFF_FFFC;

   initial begin
      checks = 0;
      errors = 0;
      // redir, base, off, jalr, ready | pc, valid, wp, mis, add_a, add_b
      vq.push_back(mk(0, 0, 0, 0, 1,  'h0, 0, 0, 0, 'h0, 'h4));      // boot
      vq.push_back(mk(0, 0, 0, 0, 1,  'h0, 1, 0, 0, 'h0, 'h4));
      vq.push_back(mk(0, 0, 0, 0, 1,  'h4, 1, 0, 0, 'h4, 'h4));
      vq.push_back(mk(0, 0, 0, 0, 1,  'h8, 1, 0, 0, 'h8, 'h4));
      vq.push_back(mk(0, 0, 0, 0, 1,  'hC, 1, 0, 0, 'hC, 'h4));
      vq.push_back(mk(1, 'h8, 0, 0, 1, 'h10, 1, 0, 0, 'h8, 'h0));    // back to 0x8
      vq.push_back(mk(1, 'h8, M8, 0, 1, 'h8, 1, 0, 0, 'h8, M8));     // 8 + (-8)
      vq.push_back(mk(0, 0, 0, 0, 1,  'h0, 1, 0, 0, 'h0, 'h4));
      vq.push_back(mk(0, 0, 0, 0, 1,  'h4, 1, 0, 0, 'h4, 'h4));
      vq.push_back(mk(0, 0, 0, 0, 1,  'h8, 1, 0, 0, 'h8, 'h4));
      vq.push_back(mk(0, 0, 0, 0, 1,  'hC, 1, 0, 0, 'hC, 'h4));
      vq.push_back(mk(1, 'h100, 'h20, 0, 0, 'h10, 1, 0, 0, 'h100, 'h20)); // stall redirect
      vq.push_back(mk(0, 0, 0, 0, 0,  'h10, 1, 1, 0, 'h10, 'h4));
      vq.push_back(mk(0, 0, 0, 0, 0,  'h10, 1, 1, 0, 'h10, 'h4));
      vq.push_back(mk(0, 0, 0, 0, 1,  'h10, 1, 1, 0, 'h10, 'h4));    // flagged transfer
      vq.push_back(mk(1, 'h100, 'h20, 0, 0, 'h120, 1, 0, 0, 'h100, 'h20));
      vq.push_back(mk(1, 'h200, 'h4, 0, 0, 'h120, 1, 1, 0, 'h200, 'h4)); // newest wins
      vq.push_back(mk(0, 0, 0, 0, 1,  'h120, 1, 1, 0, 'h120, 'h4));
      vq.push_back(mk(0, 0, 0, 0, 1,  'h204, 1, 0, 0, 'h204, 'h4));
      vq.push_back(mk(1, 'h400, 0, 0, 0, 'h208, 1, 0, 0, 'h400, 'h0));
      vq.push_back(mk(1, 'h500, 'h10, 0, 1, 'h208, 1, 1, 0, 'h500, 'h10)); // redirect+fire in pend
      vq.push_back(mk(1, 'h1001, 'h2, 1, 0, 'h510, 1, 0, 0, 'h1001, 'h2)); // jalr -> 0x1002
      vq.push_back(mk(0, 0, 0, 0, 0,  'h510, 1, 0, 1, 'h510, 'h4));
      vq.push_back(mk(1, 'h1001, 'h3, 1, 1, 'h510, 1, 0, 0, 'h1001, 'h3)); // jalr -> 0x1004
      vq.push_back(mk(1, TOP, 'hC, 0, 1, 'h1004, 1, 0, 0, TOP, 'hC));
      vq.push_back(mk(0, 0, 0, 0, 1,  TFC, 1, 0, 0, TFC, 'h4));      // wraps to 0
      vq.push_back(mk(1, 'h40, 0, 0, 0, 'h0, 1, 0, 0, 'h40, 'h0));
      vq.push_back(mk(0, 0, 0, 0, 0,  'h0, 1, 1, 0, 'h0, 'h4));      // in pend, pending 0x40

      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      foreach (vq[i]) begin
         drive(vq[i].redir, vq[i].base, vq[i].off, vq[i].jalr, vq[i].ready);
         #2;
         chk_regs($sformatf("v%0d", i), vq[i].exp_pc, vq[i].exp_valid, vq[i].exp_wp,
                  vq[i].exp_mis);
         chk($sformatf("v%0d add_a", i), bus.o_add_a, vq[i].exp_a);
         chk($sformatf("v%0d add_b", i), bus.o_add_b, vq[i].exp_b);
         @(posedge clk);
         #1;
      end

      // Reset while pending with fetch ready: no transfer completes, all cleared.
      rst = 1'b1;
      drive(0, 0, 0, 0, 1);
      @(posedge clk);
      #1;
      chk_regs("rst", 'h0, 0, 0, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk_regs("post_rst boot", 'h0, 1, 0, 0);
      @(posedge clk);
      #1;
      // Pending 0x40 must not reappear after reset.
      chk_regs("post_rst seq", 'h4, 1, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and arbitrates the single shared 64-bit PC adder between two requesters:
  - sequential increment (PC + INSTR_BYTES);
  - control-flow redirect (base + offset, used for branch, JAL and JALR).
- Presents each PC to instruction fetch over a valid/ready handshake.
- Buffers a redirect that arrives while a fetch transfer is stalled, and flags the wrong-path transfer.

Parameters:
- DATA_WIDTH, 64, width of PC and adder operands.
- RESET_VECTOR, 64'h0000_0000_0000_0000, PC value after reset.
- INSTR_BYTES, 4, sequential PC increment.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- o_add_a  output  DATA_WIDTH  operand A to the shared Adder.
- o_add_b  output  DATA_WIDTH  operand B to the shared Adder.
- i_add_result  input  DATA_WIDTH  Adder sum (combinational, same cycle).
- o_pc  output  DATA_WIDTH  PC offered to fetch.
- o_pc_valid  output  1  o_pc is a valid fetch request.
- i_fetch_ready  input  1  fetch accepts o_pc this cycle.
- o_wrong_path  output  1  qualifies the current transfer as wrong-path (fetch discards it).
- i_redir_req  input  1  one-cycle redirect request from execute.
- i_redir_base  input  DATA_WIDTH  redirect base (branch PC or rs1).
- i_redir_offset  input  DATA_WIDTH  sign-extended immediate.
- i_redir_jalr  input  1  clear bit 0 of the computed target (JALR rule).
- o_misaligned  output  1  one-cycle pulse: redirect target not INSTR_BYTES-aligned.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - o_pc=RESET_VECTOR, o_pc_valid=0, o_wrong_path=0, o_misaligned=0.
  - Pending register cleared; state=BOOT.
  - Reset applied mid-handshake or while PEND simply aborts; no transfer completes in the reset cycle.
- fire = o_pc_valid & i_fetch_ready.
- Adder arbitration (combinational, one grant per cycle):
  - If i_redir_req=1: o_add_a=i_redir_base, o_add_b=i_redir_offset. Redirect always wins.
  - Otherwise: o_add_a=o_pc, o_add_b=INSTR_BYTES.
  - target = i_add_result with bit 0 forced to 0 when i_redir_jalr=1.
  - Sum wraps modulo 2^DATA_WIDTH; no overflow flag.
- Alignment check:
  - A target with target[1:0]!=0 pulses o_misaligned=1 the next cycle.
  - That redirect is dropped; state, PC and pending register are unchanged.
- State BOOT:
  - Next cycle: state=RUN, o_pc_valid=1, o_pc=RESET_VECTOR.
  - Redirects in BOOT are ignored.
- State RUN (o_pc_valid=1, o_wrong_path=0):
  - Redirect with fire: o_pc<=target, stay RUN. The accepted transfer is the pre-redirect PC and is not flagged; execute squashes it.
  - Redirect without fire: o_pc held stable (handshake rule), pending<=target, state<=PEND.
  - No redirect, fire: o_pc<=i_add_result (o_pc+INSTR_BYTES).
  - No redirect, no fire: all held.
- State PEND (o_pc_valid=1, o_wrong_path=1, o_pc held):
  - New redirect: pending<=new target (newest wins), stay PEND unless fire is also asserted this cycle.
  - Redirect together with fire: o_pc<=new target, state<=RUN.
  - Fire without redirect: o_pc<=pending, state<=RUN.
  - Sequential increment is never applied in PEND.
- Latency:
  - Redirect to new o_pc: 1 cycle when fetch is ready.
  - Otherwise new o_pc appears the cycle after the stalled transfer completes.
- Invariant: o_pc never changes while o_pc_valid=1 and i_fetch_ready=0, except on reset.

Test Plan:
1. Reset, then hold i_fetch_ready=1 for 4 cycles:
   - o_pc_valid rises one cycle after reset release.
   - Accepted PCs are 0x0, 0x4, 0x8, 0xC.
   - o_add_a/o_add_b show o_pc/4 on each cycle.
2. Redirect at o_pc=0x8 with base=0x8, offset=0xFFFF_FFFF_FFFF_FFF8 (-8), ready=1:
   - Next o_pc=0x0; o_wrong_path stays 0.
3. Ready=0 at o_pc=0x10; redirect base=0x100, offset=0x20; hold ready=0 for 3 cycles, then 1:
   - o_pc stays 0x10 with o_wrong_path=1 throughout.
   - Transfer of 0x10 completes flagged; next o_pc=0x120.
4. While PEND (pending 0x120), second redirect base=0x200, offset=0x4:
   - Pending becomes 0x204; after fire, o_pc=0x204.
5. JALR redirect base=0x1001, offset=0x2, jalr=1:
   - Target 0x1002 is misaligned; o_misaligned pulses once.
   - o_pc sequence unaffected.
   - Repeat with base=0x1001, offset=0x3: target 0x1004 is accepted.
6. Wrap and reset:
   - o_pc=0xFFFF_FFFF_FFFF_FFFC with fire gives o_pc=0x0.
   - Assert i_rst during PEND: next cycle o_pc=RESET_VECTOR, o_pc_valid=0, o_wrong_path=0, pending cleared.
